// File: rtl/parity_pkg.sv
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared types and default widths for the byte parity stage
//                and the frame parity checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

   // Default parity word width, shared with the upstream byte parity stage
   localparam int PARITY_DATA_WIDTH = 8;

   // Default number of bytes per frame
   localparam int PARITY_FRAME_LEN  = 16;

   // Frame checker state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } pf_state_t;

endpackage

`default_nettype wire

// File: rtl/parity_sat_counter.sv
// ============================================================================
//  Module      : parity_sat_counter
//  Description : Generic up-counter that sticks at its all-ones value.
//                Only compiled when PARITY_ERR_CNT_EN is defined, which is
//                the only build that instantiates it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PARITY_ERR_CNT_EN
module parity_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count increment requests, holding at the maximum value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule
`endif

`default_nettype wire

// File: rtl/parity_frame_checker.sv
// ============================================================================
//  Module      : parity_frame_checker
//  Description : XOR-accumulates per-byte parity words over a frame of
//                FRAME_LEN bytes, reports the frame parity and compares it
//                against a reference latched at frame start. A sticky
//                overrun flag catches results arriving outside a frame.
//                Optional feature macro: PARITY_ERR_CNT_EN adds a 16-bit
//                saturating mismatch counter on output err_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = PARITY_DATA_WIDTH,
   parameter int FRAME_LEN  = PARITY_FRAME_LEN,
   parameter int CNT_W      = $clog2(FRAME_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_start,
   input  logic [DATA_WIDTH-1:0] expected_parity,
   input  logic [DATA_WIDTH-1:0] byte_parity,
   input  logic                  done,
   output logic                  busy,
   output logic [CNT_W-1:0]      byte_count,
   output logic [DATA_WIDTH-1:0] frame_parity,
   output logic                  frame_valid,
   output logic                  parity_error,
   output logic                  overrun
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [15:0]           err_count
`endif
);

   // Count value held when the final byte of a frame arrives
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   pf_state_t             state;
   pf_state_t             next_state;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] exp_q;
   logic [DATA_WIDTH-1:0] acc_next_xor;
   logic                  last_byte;
   logic                  busy_d;
   logic                  valid_d;

   // Final byte of the frame: a restart in the same cycle takes priority
   assign last_byte    = (state == ACCUM) && done && !frame_start &&
                         (byte_count == LAST_IDX);
   assign acc_next_xor = acc ^ byte_parity;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; frame_start restarts from any state
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (frame_start) next_state = ACCUM;
         end
         ACCUM: begin
            if (frame_start)    next_state = ACCUM;
            else if (last_byte) next_state = REPORT;
         end
         REPORT: begin
            next_state = frame_start ? ACCUM : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode from the upcoming state so busy/frame_valid leave flops
   always_comb begin
      busy_d  = (next_state == ACCUM);
      valid_d = (next_state == REPORT);
   end

   // Datapath: accumulator, counter, reference latch, results and flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy         <= 1'b0;
         frame_valid  <= 1'b0;
         acc          <= '0;
         exp_q        <= '0;
         byte_count   <= '0;
         frame_parity <= '0;
         parity_error <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         busy        <= busy_d;
         frame_valid <= valid_d;

         // A new frame seeds with the coincident byte, if any
         if (frame_start) begin
            exp_q      <= expected_parity;
            acc        <= done ? byte_parity : '0;
            byte_count <= done ? CNT_W'(1) : '0;
         end else if ((state == ACCUM) && done) begin
            acc        <= acc_next_xor;
            byte_count <= byte_count + CNT_W'(1);
         end

         // Results load on entry to REPORT and hold until the next one
         if (last_byte) begin
            frame_parity <= acc_next_xor;
            parity_error <= (acc_next_xor != exp_q);
         end

         // Clear on frame_start wins over a simultaneous stray byte
         if (frame_start) begin
            overrun <= 1'b0;
         end else if (done && (state != ACCUM)) begin
            overrun <= 1'b1;
         end
      end
   end

`ifdef PARITY_ERR_CNT_EN
   // frame_valid marks the REPORT cycle, where parity_error is current
   parity_sat_counter #(
      .WIDTH (16)
   ) u_err_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (frame_valid && parity_error),
      .count   (err_count)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
// ============================================================================
//  Module      : tb_parity_frame_checker
//  Description : Self-checking bench for parity_frame_checker, FRAME_LEN=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_checker;

   localparam int DW = 8;
   localparam int FL = 4;
   localparam int CW = $clog2(FL + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          frame_start = 1'b0;
   logic [DW-1:0] expected_parity = '0;
   logic [DW-1:0] byte_parity = '0;
   logic          done = 1'b0;
   logic          busy;
   logic [CW-1:0] byte_count;
   logic [DW-1:0] frame_parity;
   logic          frame_valid;
   logic          parity_error;
   logic          overrun;
`ifdef PARITY_ERR_CNT_EN
   logic [15:0]   err_count;
`endif

   typedef struct packed {
      logic [DW-1:0] par;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails = 0;
   int   valid_seen = 0;
   int   err_model = 0;

   parity_frame_checker #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (FL)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .frame_start     (frame_start),
      .expected_parity (expected_parity),
      .byte_parity     (byte_parity),
      .done            (done),
      .busy            (busy),
      .byte_count      (byte_count),
      .frame_parity    (frame_parity),
      .frame_valid     (frame_valid),
      .parity_error    (parity_error),
      .overrun         (overrun)
`ifdef PARITY_ERR_CNT_EN
      ,
      .err_count       (err_count)
`endif
   );

   always #5 clk = ~clk;

   // One clock of stimulus; returns 1 time unit after the sampling edge
   task automatic cyc(input logic fs, input logic [DW-1:0] ep,
                      input logic dn, input logic [DW-1:0] bp);
      frame_start     = fs;
      expected_parity = ep;
      done            = dn;
      byte_parity     = bp;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      done        = 1'b0;
   endtask

   function automatic logic [DW-1:0] xor4(input logic [31:0] bytes);
      logic [DW-1:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) p = p ^ bytes[8*i +: 8];
      return p;
   endfunction

   // Reference result for a frame goes into the scoreboard before it runs
   task automatic push_frame(input logic [31:0] bytes, input logic [DW-1:0] ep);
      exp_t e;
      e.par = xor4(bytes);
      e.err = (e.par != ep);
      if (e.err) err_model++;
      sb.push_back(e);
   endtask

   task automatic run_bytes(input logic [31:0] bytes, input int gap);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b1, bytes[8*i +: 8]);
         if (i < 3) repeat (gap) cyc(1'b0, '0, 1'b0, '0);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (byte_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", byte_count); end
      checks++; if (frame_parity !== '0) begin fails++; $display("FAIL reset_parity: got %h want 00", frame_parity); end
      checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
      checks++; if (parity_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", parity_error); end
      checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
`ifdef PARITY_ERR_CNT_EN
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
`endif
      reset_n = 1'b1;
      cyc(1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_basic;
      push_frame(32'h08040201, 8'h00);
      cyc(1'b1, 8'h00, 1'b0, '0);
      run_bytes(32'h08040201, 0);
      checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", frame_valid); end
      checks++; if (byte_count !== CW'(4)) begin fails++; $display("FAIL basic_count: got %0d want 4", byte_count); end
      cyc(1'b0, '0, 1'b0, '0);
      checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse: got %b want 0", frame_valid); end
      checks++; if (frame_parity !== 8'h0F) begin fails++; $display("FAIL basic_hold: got %h want 0f", frame_parity); end
      checks++; if (parity_error !== 1'b1) begin fails++; $display("FAIL basic_err_hold: got %b want 1", parity_error); end
   endtask

   task automatic test_matching;
      push_frame(32'h08040201, 8'h0F);
      cyc(1'b1, 8'h0F, 1'b0, '0);
      cyc(1'b0, '0, 1'b1, 8'h01);
      repeat (3) cyc(1'b0, '0, 1'b0, '0);
      cyc(1'b0, '0, 1'b1, 8'h02);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL match_busy: got %b want 1", busy); end
      checks++; if (byte_count !== CW'(2)) begin fails++; $display("FAIL match_mid_count: got %0d want 2", byte_count); end
      repeat (3) cyc(1'b0, '0, 1'b0, '0);
      cyc(1'b0, '0, 1'b1, 8'h04);
      repeat (3) cyc(1'b0, '0, 1'b0, '0);
      cyc(1'b0, '0, 1'b1, 8'h08);
      checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL match_valid: got %b want 1", frame_valid); end
      cyc(1'b0, '0, 1'b0, '0);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL match_busy_after: got %b want 0", busy); end
      checks++; if (byte_count !== CW'(4)) begin fails++; $display("FAIL match_count: got %0d want 4", byte_count); end
   endtask

   task automatic test_same_cycle;
      push_frame(32'h00FF55AA, 8'h00);
      cyc(1'b1, 8'h00, 1'b1, 8'hAA);
      checks++; if (byte_count !== CW'(1)) begin fails++; $display("FAIL same_count: got %0d want 1", byte_count); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL same_busy: got %b want 1", busy); end
      cyc(1'b0, '0, 1'b1, 8'h55);
      cyc(1'b0, '0, 1'b1, 8'hFF);
      cyc(1'b0, '0, 1'b1, 8'h00);
      checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL same_valid: got %b want 1", frame_valid); end
      cyc(1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_abort;
      int v0;
      v0 = valid_seen;
      cyc(1'b1, 8'h77, 1'b0, '0);
      cyc(1'b0, '0, 1'b1, 8'h01);
      cyc(1'b0, '0, 1'b1, 8'h02);
      push_frame(32'h00002211, 8'h33);
      cyc(1'b1, 8'h33, 1'b0, '0);
      checks++; if (byte_count !== CW'(0)) begin fails++; $display("FAIL abort_count: got %0d want 0", byte_count); end
      run_bytes(32'h00002211, 0);
      repeat (2) cyc(1'b0, '0, 1'b0, '0);
      checks++; if (valid_seen - v0 != 1) begin fails++; $display("FAIL abort_pulses: got %0d want 1", valid_seen - v0); end
   endtask

   task automatic test_overrun;
      cyc(1'b0, '0, 1'b1, 8'h5A);
      checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", overrun); end
      checks++; if (byte_count !== CW'(4)) begin fails++; $display("FAIL ovr_count: got %0d want 4", byte_count); end
      push_frame(32'h01010101, 8'h00);
      cyc(1'b1, 8'h00, 1'b0, '0);
      checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun); end
      run_bytes(32'h01010101, 0);
      // Now in REPORT: a stray byte here sets overrun and is discarded
      cyc(1'b0, '0, 1'b1, 8'hFF);
      checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_report: got %b want 1", overrun); end
      checks++; if (frame_parity !== 8'h00) begin fails++; $display("FAIL ovr_discard: got %h want 00", frame_parity); end
      push_frame(32'h00000010, 8'h10);
      cyc(1'b1, 8'h10, 1'b1, 8'h10);
      checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear_wins: got %b want 0", overrun); end
      checks++; if (byte_count !== CW'(1)) begin fails++; $display("FAIL ovr_seed_count: got %0d want 1", byte_count); end
      repeat (3) cyc(1'b0, '0, 1'b1, 8'h00);
      cyc(1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_reset_mid;
      int v0;
      push_frame(32'h000000C3, 8'h00);
      cyc(1'b1, 8'h00, 1'b0, '0);
      run_bytes(32'h000000C3, 0);
      cyc(1'b0, '0, 1'b0, '0);
      cyc(1'b1, 8'h00, 1'b0, '0);
      cyc(1'b0, '0, 1'b1, 8'h12);
      cyc(1'b0, '0, 1'b1, 8'h34);
      v0 = valid_seen;
      #2 reset_n = 1'b0;
      #1;
      err_model = 0;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
      checks++; if (byte_count !== '0) begin fails++; $display("FAIL rmid_count: got %0d want 0", byte_count); end
      checks++; if (frame_parity !== '0) begin fails++; $display("FAIL rmid_parity: got %h want 00", frame_parity); end
      checks++; if (parity_error !== 1'b0) begin fails++; $display("FAIL rmid_error: got %b want 0", parity_error); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (6) cyc(1'b0, '0, 1'b0, '0);
      checks++; if (valid_seen != v0) begin fails++; $display("FAIL rmid_no_valid: got %0d want %0d", valid_seen, v0); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_idle: got %b want 0", busy); end
   endtask

`ifdef PARITY_ERR_CNT_EN
   task automatic test_err_count;
      for (int f = 0; f < 3; f++) begin
         push_frame(32'h00000001 << f, 8'hE0);
         cyc(1'b1, 8'hE0, 1'b0, '0);
         run_bytes(32'h00000001 << f, 0);
      end
      cyc(1'b0, '0, 1'b0, '0);
      checks++; if (err_count !== 16'(err_model)) begin fails++; $display("FAIL errcnt_value: got %0d want %0d", err_count, err_model); end
      #2 reset_n = 1'b0;
      #1;
      err_model = 0;
      checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL errcnt_reset: got %0d want 0", err_count); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      cyc(1'b0, '0, 1'b0, '0);
   endtask
`endif

   initial begin
      // Scoreboard monitor: each frame_valid pops one expected frame
      fork
         forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
               exp_t e;
               valid_seen++;
               checks++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL sb_unexpected: got frame_valid parity %h want no frame", frame_parity);
               end else begin
                  e = sb.pop_front();
                  if (frame_parity !== e.par || parity_error !== e.err) begin
                     fails++;
                     $display("FAIL sb_frame: got parity %h err %b want parity %h err %b",
                              frame_parity, parity_error, e.par, e.err);
                  end
               end
            end
         end
      join_none

      test_reset();
      test_basic();
      test_matching();
      test_same_cycle();
      test_abort();
      test_overrun();
      test_reset_mid();
`ifdef PARITY_ERR_CNT_EN
      test_err_count();
`endif
      repeat (2) cyc(1'b0, '0, 1'b0, '0);
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: got %0d outstanding frames want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/parity_frame_checker.md
# parity_frame_checker

Downstream consumer of the byte parity stage. It accumulates the per-byte parity words that stage produces (one per `done` pulse) across a frame of `FRAME_LEN` bytes by bitwise XOR. At frame end it reports the frame parity and compares it against an expected value latched at frame start. A sticky overrun flag catches results that arrive outside a frame.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of the parity word; must match the upstream stage.
- `FRAME_LEN`, 16, bytes per frame; legal range is 2..65535.
- `CNT_W`, `$clog2(FRAME_LEN+1)`, width of the byte counter (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse that opens a frame and latches `expected_parity`.
- `expected_parity`  in  DATA_WIDTH  reference parity, sampled only on `frame_start`.
- `byte_parity`  in  DATA_WIDTH  parity word from the upstream stage; valid only when `done`=1.
- `done`  in  1  upstream result strobe; each cycle high counts as one byte.
- `busy`  out  1  high in ACCUM.
- `byte_count`  out  CNT_W  bytes accumulated in the current frame.
- `frame_parity`  out  DATA_WIDTH  XOR of all bytes of the last completed frame.
- `frame_valid`  out  1  one-cycle pulse when a frame completes.
- `parity_error`  out  1  `frame_parity != expected`; updated with `frame_valid`.
- `overrun`  out  1  sticky; set by `done` outside ACCUM.

## Operation
- FSM has three states: IDLE, ACCUM and REPORT. Reset state is IDLE.
- **IDLE**
  - `frame_start` moves to ACCUM, sets acc=0 and count=0, and latches `expected_parity` into exp_q.
  - If `done` is high in the same cycle, byte 0 is accumulated: acc=`byte_parity`, count=1.
- **ACCUM**
  - On `done`: acc ^= `byte_parity` and count++.
  - If count==FRAME_LEN-1 when `done` arrives, go to REPORT.
  - A `frame_start` in ACCUM aborts the current frame and restarts as in IDLE, including the same-cycle `done` rule. No `frame_valid` is produced for the aborted frame.
- **REPORT** (exactly one cycle)
  - `frame_valid`=1 and `frame_parity`=acc.
  - `parity_error`=(acc != exp_q).
  - Next state is IDLE. If `frame_start` is high in REPORT, next state is ACCUM as from IDLE.
- **Overrun**
  - `done` in IDLE without `frame_start`, or `done` in REPORT without `frame_start`, sets `overrun` and the byte is discarded.
  - `frame_start` clears `overrun`. If both events occur in the same cycle, clear wins.
- `frame_parity` and `parity_error` hold until the next REPORT.
- `byte_count` resets to 0 on `frame_start`. It is not cleared on REPORT, so it reads FRAME_LEN until the next frame.
- All arithmetic is unsigned. `byte_count` never exceeds FRAME_LEN.

## Timing
- Reset values: state IDLE; `busy`, `frame_valid`, `parity_error` and `overrun` are 0; `frame_parity`, `byte_count`, acc and exp_q are 0.
- Latency: `frame_valid` rises in the cycle after the clock edge that samples the last `done`. All outputs are registered.
- `done` may be high on consecutive cycles; every cycle counts as one byte. No backpressure exists, and the block accepts one byte per cycle.
- Minimum frame period is FRAME_LEN+1 cycles, or FRAME_LEN cycles if `frame_start` coincides with REPORT.
- Reset asserted mid-frame returns the block to IDLE immediately. No `frame_valid` is produced and the partial accumulation is lost.

## Configuration
- `PARITY_ERR_CNT_EN` defined:
  - Adds output `err_count` (16 bits) and 16-bit register err_cnt.
  - err_cnt increments on each REPORT with a mismatch, saturates at 0xFFFF, and resets to 0.
  - It is not cleared by `frame_start`.
- `PARITY_ERR_CNT_EN` undefined: the port and register are absent. All other behaviour is identical.

## Structure
- Shared package `parity_pkg` holds:
  - the FSM state enum `pf_state_t` (IDLE, ACCUM, REPORT);
  - the default widths `PARITY_DATA_WIDTH`=8 and `PARITY_FRAME_LEN`=16.
- The byte_parity stage imports the same width constant.
- One sub-module is natural: `parity_sat_counter`, a generic saturating counter. It is used for err_cnt and is instantiated only under `PARITY_ERR_CNT_EN`. Everything else stays flat.

## Test plan
All scenarios use FRAME_LEN=4 and DATA_WIDTH=8.
1. Basic frame: `frame_start` with exp=0x00, then `done` with 0x01, 0x02, 0x04, 0x08 on consecutive cycles. Required: `frame_valid` pulse one cycle after the 4th byte, `frame_parity`=0x0F, `parity_error`=1.
2. Matching frame: exp=0x0F and the same bytes with idle gaps of 3 cycles. Required: `frame_parity`=0x0F, `parity_error`=0, `byte_count`=4, `busy` low after REPORT.
3. Same-cycle start: `frame_start` together with `done`=0xAA, then 0x55, 0xFF, 0x00. Required: `frame_parity`=0x00 and `frame_valid` after the 4th byte.
4. Abort: `frame_start`, 2 bytes, then `frame_start` with exp=0x33, then 4 bytes 0x11, 0x22, 0x00, 0x00. Required: exactly one `frame_valid`, `frame_parity`=0x33, `parity_error`=0.
5. Overrun: `done` in IDLE sets `overrun`=1 and leaves `byte_count` unchanged. The next `frame_start` clears it. `done` in the REPORT cycle sets it again.
6. Reset mid-frame: `reset_n` low after 2 bytes. Required: all outputs return to reset values asynchronously and no `frame_valid` follows. With `PARITY_ERR_CNT_EN`, 3 mismatching frames give `err_count`=3, and `err_count` is 0 after reset.
